// File: rtl/eink_panel_responder_pkg.sv
// Shared constants and state encodings for the e-ink panel responder.
// Mirrors the driver-side definitions so both ends agree on command codes.
package eink_panel_responder_pkg;

    localparam logic [7:0] CMD_SWRESET    = 8'h12;
    localparam logic [7:0] CMD_MASTER_ACT = 8'h20;

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_e;

    typedef enum logic [1:0] {
        BUSY_READY = 2'b00,
        BUSY_HWRST = 2'b01,
        BUSY_CMD   = 2'b10
    } busy_state_e;

endpackage

// File: rtl/eink_panel_responder_if.sv
// Panel-side SPI pin bundle: driver owns csb/sck/mosi/dcb/resetb, panel owns busy.
interface eink_panel_responder_if;
    logic csb;
    logic sck;
    logic mosi;
    logic dcb;
    logic resetb;
    logic busy;

    modport master (output csb, output sck, output mosi, output dcb, output resetb, input busy);
    modport slave  (input csb, input sck, input mosi, input dcb, input resetb, output busy);
endinterface

// File: rtl/eink_spi_byte_rx.sv
// Oversampling SPI mode-0 byte receiver: synchronizers, edge detect, shift register,
// bit count and frame-error detection. Emits one registered pulse per completed byte.
module eink_spi_byte_rx
    import eink_panel_responder_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       csb,
    input  logic       sck,
    input  logic       mosi,
    input  logic       dcb,
    input  logic       resetb,
    output logic       resetb_sync,
    output logic       byte_done,
    output logic       byte_dc,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    // Idle pin levels {resetb, dcb, mosi, sck, csb} so reset release looks quiet.
    localparam logic [4:0] PINS_IDLE = 5'b10001;

    logic [SYNC_STAGES-1:0][4:0] sync_r;
    logic [4:0] pins_s;
    logic       csb_s, sck_s, mosi_s, dcb_s, resetb_s;
    logic       csb_prev_r, sck_prev_r;
    logic       csb_fall_s, csb_rise_s, sck_rise_s;

    rx_state_e  state_r, state_next_s;
    logic [7:0] shift_r, shift_next_s;
    logic [2:0] bit_cnt_r, bit_cnt_next_s;
    logic [7:0] data_r, data_next_s;
    logic       dc_r, dc_next_s;
    logic       done_r, done_next_s;
    logic       err_r, err_next_s;

    assign pins_s   = {resetb, dcb, mosi, sck, csb};
    assign csb_s    = sync_r[SYNC_STAGES-1][0];
    assign sck_s    = sync_r[SYNC_STAGES-1][1];
    assign mosi_s   = sync_r[SYNC_STAGES-1][2];
    assign dcb_s    = sync_r[SYNC_STAGES-1][3];
    assign resetb_s = sync_r[SYNC_STAGES-1][4];

    assign csb_fall_s = ~csb_s & csb_prev_r;
    assign csb_rise_s = csb_s & ~csb_prev_r;
    assign sck_rise_s = sck_s & ~sck_prev_r;

    // Input synchronizer chain and edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r     <= {SYNC_STAGES{PINS_IDLE}};
            csb_prev_r <= 1'b1;
            sck_prev_r <= 1'b0;
        end else begin
            sync_r     <= {sync_r[SYNC_STAGES-2:0], pins_s};
            csb_prev_r <= csb_s;
            sck_prev_r <= sck_s;
        end
    end

    // Receive FSM next-state: panel reset overrides everything, csb rise ends the frame.
    always_comb begin
        state_next_s   = state_r;
        shift_next_s   = shift_r;
        bit_cnt_next_s = bit_cnt_r;
        data_next_s    = data_r;
        dc_next_s      = dc_r;
        done_next_s    = 1'b0;
        err_next_s     = 1'b0;
        if (!resetb_s) begin
            state_next_s   = RX_IDLE;
            shift_next_s   = 8'h00;
            bit_cnt_next_s = 3'd0;
        end else begin
            case (state_r)
                RX_IDLE: begin
                    if (csb_fall_s) begin
                        state_next_s   = RX_SHIFT;
                        shift_next_s   = 8'h00;
                        bit_cnt_next_s = 3'd0;
                    end else begin
                        state_next_s = RX_IDLE;
                    end
                end
                RX_SHIFT: begin
                    if (sck_rise_s) begin
                        shift_next_s   = {shift_r[6:0], mosi_s};
                        bit_cnt_next_s = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            done_next_s = 1'b1;
                            data_next_s = {shift_r[6:0], mosi_s};
                            dc_next_s   = dcb_s;
                        end else begin
                            done_next_s = 1'b0;
                        end
                    end else begin
                        shift_next_s = shift_r;
                    end
                    // A byte finishing on the same clock as csb rise is complete, not partial.
                    if (csb_rise_s) begin
                        state_next_s   = RX_IDLE;
                        err_next_s     = sck_rise_s ? (bit_cnt_r != 3'd7) : (bit_cnt_r != 3'd0);
                        shift_next_s   = 8'h00;
                        bit_cnt_next_s = 3'd0;
                    end else begin
                        state_next_s = RX_SHIFT;
                    end
                end
                default: begin
                    state_next_s   = RX_IDLE;
                    shift_next_s   = 8'h00;
                    bit_cnt_next_s = 3'd0;
                end
            endcase
        end
    end

    // Receive FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= RX_IDLE;
            shift_r   <= 8'h00;
            bit_cnt_r <= 3'd0;
            data_r    <= 8'h00;
            dc_r      <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            shift_r   <= shift_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            data_r    <= data_next_s;
            dc_r      <= dc_next_s;
            done_r    <= done_next_s;
            err_r     <= err_next_s;
        end
    end

    assign resetb_sync = resetb_s;
    assign byte_done   = done_r;
    assign byte_dc     = dc_r;
    assign byte_data   = data_r;
    assign frame_err   = err_r;

endmodule

// File: rtl/eink_panel_responder.sv
// E-ink panel SPI responder: byte tagging, command decode, data counting and
// the busy countdown that emulates hardware reset, soft reset and display refresh.
module eink_panel_responder
    import eink_panel_responder_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int HWRST_CYCLES = 200,
    parameter int SWRST_CYCLES = 400,
    parameter int ACT_CYCLES   = 1000,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    eink_panel_responder_if.slave spi,
    output logic                 cmd_valid,
    output logic                 data_valid,
    output logic [7:0]           rx_byte,
    output logic [7:0]           last_cmd,
    output logic [CNT_W-1:0]     data_count,
    output logic                 frame_err,
    output logic                 busy_viol
);

    localparam logic [CNT_W-1:0] HWRST_LOAD = CNT_W'(HWRST_CYCLES);
    localparam logic [CNT_W-1:0] SWRST_LOAD = CNT_W'(SWRST_CYCLES);
    localparam logic [CNT_W-1:0] ACT_LOAD   = CNT_W'(ACT_CYCLES);

    logic       resetb_sync_s;
    logic       byte_done_s;
    logic       byte_dc_s;
    logic [7:0] byte_data_s;
    logic       is_cmd_s;

    busy_state_e      bstate_r, bstate_next_s;
    logic [CNT_W-1:0] bcnt_r, bcnt_next_s;
    logic             busy_r;
    logic             cmd_valid_r, data_valid_r, busy_viol_r;
    logic [7:0]       rx_byte_r, last_cmd_r;
    logic [CNT_W-1:0] data_count_r;

    eink_spi_byte_rx #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .csb         (spi.csb),
        .sck         (spi.sck),
        .mosi        (spi.mosi),
        .dcb         (spi.dcb),
        .resetb      (spi.resetb),
        .resetb_sync (resetb_sync_s),
        .byte_done   (byte_done_s),
        .byte_dc     (byte_dc_s),
        .byte_data   (byte_data_s),
        .frame_err   (frame_err)
    );

    assign is_cmd_s = byte_done_s & ~byte_dc_s;

    // Busy FSM next-state: timed commands reload the countdown, never accumulate.
    always_comb begin
        bstate_next_s = bstate_r;
        bcnt_next_s   = bcnt_r;
        if (!resetb_sync_s) begin
            bstate_next_s = BUSY_HWRST;
            bcnt_next_s   = HWRST_LOAD;
        end else if (is_cmd_s && (byte_data_s == CMD_SWRESET)) begin
            bstate_next_s = BUSY_CMD;
            bcnt_next_s   = SWRST_LOAD;
        end else if (is_cmd_s && (byte_data_s == CMD_MASTER_ACT)) begin
            bstate_next_s = BUSY_CMD;
            bcnt_next_s   = ACT_LOAD;
        end else begin
            case (bstate_r)
                BUSY_READY: begin
                    bstate_next_s = BUSY_READY;
                end
                BUSY_HWRST, BUSY_CMD: begin
                    bcnt_next_s = bcnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    if (bcnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        bstate_next_s = BUSY_READY;
                    end else begin
                        bstate_next_s = bstate_r;
                    end
                end
                default: begin
                    bstate_next_s = BUSY_READY;
                end
            endcase
        end
    end

    // Busy FSM state, countdown and registered busy pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bstate_r <= BUSY_HWRST;
            bcnt_r   <= HWRST_LOAD;
            busy_r   <= 1'b1;
        end else begin
            bstate_r <= bstate_next_s;
            bcnt_r   <= bcnt_next_s;
            busy_r   <= (bstate_next_s != BUSY_READY);
        end
    end

    // Byte tagging, last command, data counter and protocol-violation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid_r  <= 1'b0;
            data_valid_r <= 1'b0;
            busy_viol_r  <= 1'b0;
            rx_byte_r    <= 8'h00;
            last_cmd_r   <= 8'h00;
            data_count_r <= {CNT_W{1'b0}};
        end else if (!resetb_sync_s) begin
            cmd_valid_r  <= 1'b0;
            data_valid_r <= 1'b0;
            busy_viol_r  <= 1'b0;
            last_cmd_r   <= 8'h00;
            data_count_r <= {CNT_W{1'b0}};
        end else begin
            cmd_valid_r  <= is_cmd_s;
            data_valid_r <= byte_done_s & byte_dc_s;
            busy_viol_r  <= byte_done_s & busy_r;
            if (byte_done_s) begin
                rx_byte_r <= byte_data_s;
            end
            if (is_cmd_s) begin
                last_cmd_r   <= byte_data_s;
                data_count_r <= {CNT_W{1'b0}};
            end else if (byte_done_s && (data_count_r != {CNT_W{1'b1}})) begin
                data_count_r <= data_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign spi.busy   = busy_r;
    assign cmd_valid  = cmd_valid_r;
    assign data_valid = data_valid_r;
    assign busy_viol  = busy_viol_r;
    assign rx_byte    = rx_byte_r;
    assign last_cmd   = last_cmd_r;
    assign data_count = data_count_r;

endmodule
